// File: rtl/frac_shift_mult.sv
// frac_shift_mult
// Sequential fractional multiplier: result = sum over i=0..7 of
// floor(A / 2^i) * B[7-i]. A is an 8-bit unsigned operand and B is an
// unsigned Q1.7 coefficient. One term is processed per cycle. The right
// shift is done by an external 8-bit logical shifter. This block drives
// the shifter's operand and shift amount and accumulates the result it
// returns in the same cycle.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous, active-high reset
//   start      request; sampled only in IDLE or DONE
//   a_in       operand A, captured on the accepting edge
//   b_in       Q1.7 coefficient B, captured on the accepting edge
//   shift_a    registered copy of A, to the shifter
//   shift_i    current shift amount 0..7, to the shifter
//   shift_res  shifter result (shift_a >> shift_i), combinational
//   busy       high while accumulating (8 cycles)
//   done       one-cycle completion pulse
//   result     9-bit product, held until the next operation completes

module frac_shift_mult (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] a_in,
    input  logic [7:0] b_in,
    output logic [7:0] shift_a,
    output logic [2:0] shift_i,
    input  logic [7:0] shift_res,
    output logic       busy,
    output logic       done,
    output logic [8:0] result
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0] state_q,   state_d;
    logic [7:0] shift_a_q, shift_a_d;
    logic [2:0] shift_i_q, shift_i_d;
    logic [7:0] b_q,       b_d;
    logic [8:0] acc_q,     acc_d;
    logic [8:0] result_q,  result_d;

    // Coefficient bit weighting the current term: shift amount i pairs with
    // B[7-i], so the MSB (weight 1) uses the unshifted operand.
    logic       coef_bit;
    logic [8:0] acc_plus;

    assign coef_bit = b_q[3'd7 - shift_i_q];
    // Cannot overflow: the largest possible sum is 502.
    assign acc_plus = acc_q + {1'b0, shift_res};

    always_comb begin
        // NOTE: every variable gets a default before the case statement so
        // that no path leaves it unassigned, which would infer a latch.
        state_d   = state_q;
        shift_a_d = shift_a_q;
        shift_i_d = shift_i_q;
        b_d       = b_q;
        acc_d     = acc_q;
        result_d  = result_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    shift_a_d = a_in;
                    b_d       = b_in;
                    shift_i_d = 3'd0;
                    acc_d     = 9'd0;
                    state_d   = ST_RUN;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (coef_bit) begin
                    acc_d = acc_plus;
                end
                if (shift_i_q == 3'd7) begin
                    // The last term is included, so publish acc_d and not acc_q.
                    result_d  = acc_d;
                    shift_i_d = 3'd0;
                    state_d   = ST_DONE;
                end else begin
                    shift_i_d = shift_i_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so that every
        // register samples the values from before the edge.
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_a_q <= 8'd0;
            shift_i_q <= 3'd0;
            b_q       <= 8'd0;
            acc_q     <= 9'd0;
            result_q  <= 9'd0;
        end else begin
            state_q   <= state_d;
            shift_a_q <= shift_a_d;
            shift_i_q <= shift_i_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
        end
    end

    assign shift_a = shift_a_q;
    assign shift_i = shift_i_q;
    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign result  = result_q;

endmodule
